// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is purely combinational; updates and allocation happen on the rising clock edge.
module branch_target_buffer #(
  parameter int unsigned ENTRIES = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] pc,
  output logic        predict_taken,
  output logic [31:0] predict_target,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  input  logic        clear
);

  localparam int unsigned IW = $clog2(ENTRIES);
  localparam int unsigned TW = 30 - IW;

  logic          valid_q  [ENTRIES];
  logic [TW-1:0] tag_q    [ENTRIES];
  logic [31:0]   target_q [ENTRIES];
  logic [1:0]    ctr_q    [ENTRIES];

  logic [IW-1:0] lk_idx;
  logic [IW-1:0] up_idx;
  logic [TW-1:0] lk_tag;
  logic [TW-1:0] up_tag;
  logic          lk_hit;
  logic          up_hit;
  logic [1:0]    ctr_upd;

  // Byte-offset bits of the update address carry no information for word-aligned branches.
  logic unused_update_pc;
  assign unused_update_pc = ^update_pc[1:0];

  assign lk_idx = pc[IW+1:2];
  assign lk_tag = pc[31:IW+2];
  assign up_idx = update_pc[IW+1:2];
  assign up_tag = update_pc[31:IW+2];

  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    ctr_upd = ctr_q[up_idx];
    if (update_taken) begin
      if (ctr_upd != 2'b11) ctr_upd = ctr_upd + 2'd1;
    end else begin
      if (ctr_upd != 2'b00) ctr_upd = ctr_upd - 2'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (clear) begin
      // Only valid bits drop; counters and targets are left as they were.
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (update_en) begin
      if (up_hit) begin
        ctr_q[up_idx] <= ctr_upd;
        if (update_taken) target_q[up_idx] <= update_target;
      end else if (update_taken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= update_target;
        ctr_q[up_idx]    <= 2'b10;
      end
    end
  end

  always_comb begin
    predict_taken  = lk_hit && ctr_q[lk_idx][1];
    predict_target = predict_taken ? target_q[lk_idx] : pc + 32'd4;
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed and randomized checks of branch_target_buffer against an array-based
// model of the prediction table (ENTRIES = 8).
module tb_branch_target_buffer;

  localparam int unsigned ENTRIES = 8;
  localparam int unsigned IW      = 3;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        update_en = 1'b0;
  logic [31:0] update_pc = 32'h0;
  logic        update_taken = 1'b0;
  logic [31:0] update_target = 32'h0;
  logic        clear = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the table contents, indexed by word address modulo ENTRIES.
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  int unsigned m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];

  branch_target_buffer #(.ENTRIES(ENTRIES)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .pc             (pc),
    .predict_taken  (predict_taken),
    .predict_target (predict_target),
    .update_en      (update_en),
    .update_pc      (update_pc),
    .update_taken   (update_taken),
    .update_target  (update_target),
    .clear          (clear)
  );

  always #5 CLK = ~CLK;

  function automatic int unsigned idx_of(input int unsigned a);
    return (a / 4) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(input int unsigned a);
    return a / (4 * ENTRIES);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 0;
      m_tgt[i]   = 0;
      m_ctr[i]   = 1;
    end
  endtask

  task automatic model_update();
    int unsigned i;
    i = idx_of(update_pc);
    if (clear) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
    end else if (update_en) begin
      if (m_valid[i] && m_tag[i] == tag_of(update_pc)) begin
        if (update_taken) begin
          m_ctr[i] = (m_ctr[i] >= 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = update_target;
        end else begin
          m_ctr[i] = (m_ctr[i] <= 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (update_taken) begin
        m_valid[i] = 1;
        m_tag[i]   = tag_of(update_pc);
        m_tgt[i]   = update_target;
        m_ctr[i]   = 2;
      end
    end
  endtask

  task automatic cmp(input string tag, input logic exp_tk, input logic [31:0] exp_tg);
    n_cmp += 2;
    assert (predict_taken === exp_tk) else begin
      n_bad++;
      $error("FAIL %s taken: observed %b expected %b (pc %h)", tag, predict_taken, exp_tk, pc);
    end
    assert (predict_target === exp_tg) else begin
      n_bad++;
      $error("FAIL %s target: observed %h expected %h (pc %h)", tag, predict_target, exp_tg,
             pc);
    end
  endtask

  task automatic cmp_model(input string tag);
    int unsigned i;
    logic        tk;
    logic [31:0] tg;
    i  = idx_of(pc);
    tk = m_valid[i] && m_tag[i] == tag_of(pc) && m_ctr[i] >= 2;
    tg = tk ? m_tgt[i] : pc + 32'd4;
    cmp(tag, tk, tg);
  endtask

  // One clock: drive inputs just after the edge, check lookup mid-cycle, commit at next edge.
  task automatic cycle(input logic ue, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utg, input logic clr, input logic [31:0] lpc,
                       input string tag);
    update_en = ue; update_pc = upc; update_taken = ut; update_target = utg; clear = clr;
    pc = lpc;
    #3;
    cmp_model(tag);
    @(posedge CLK);
    model_update();
    #1;
    update_en = 1'b0; clear = 1'b0;
  endtask

  task automatic look(input logic [31:0] lpc, input logic exp_tk, input logic [31:0] exp_tg,
                      input string tag);
    pc = lpc;
    #1;
    cmp(tag, exp_tk, exp_tg);
    cmp_model({tag, "_model"});
  endtask

  initial begin
    model_reset();
    pc = 32'h40;
    #3;
    cmp("in_reset", 1'b0, 32'h44);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    look(32'h40, 1'b0, 32'h44, "cold");

    // Same-cycle update and lookup sees old state; allocation visible next cycle.
    cycle(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h40, "no_bypass");
    look(32'h40, 1'b1, 32'h100, "alloc_hit");

    // Saturation: WT -> ST, stays ST, then down.
    repeat (3) cycle(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h40, "sat_up");
    look(32'h40, 1'b1, 32'h100, "at_st");
    repeat (2) cycle(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h40, "sat_dn");
    look(32'h40, 1'b0, 32'h44, "at_wnt");
    repeat (3) cycle(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h40, "to_snt");
    cycle(1'b1, 32'h40, 1'b1, 32'h140, 1'b0, 32'h40, "snt_up");
    look(32'h40, 1'b0, 32'h44, "snt_plus1");
    cycle(1'b1, 32'h40, 1'b1, 32'h180, 1'b0, 32'h40, "wnt_up");
    look(32'h40, 1'b1, 32'h180, "wt_new_tgt");

    // Alias replacement at index 0.
    cycle(1'b1, 32'h60, 1'b1, 32'h200, 1'b0, 32'h60, "alias_upd");
    look(32'h40, 1'b0, 32'h44, "alias_old");
    look(32'h60, 1'b1, 32'h200, "alias_new");

    // Not-taken miss allocates nothing.
    cycle(1'b1, 32'h44, 1'b0, 32'h999, 1'b0, 32'h44, "nt_miss");
    look(32'h44, 1'b0, 32'h48, "nt_miss_chk");

    // Clear wins over a simultaneous update.
    cycle(1'b1, 32'h44, 1'b1, 32'h300, 1'b0, 32'h44, "pop44");
    look(32'h44, 1'b1, 32'h300, "pop44_chk");
    cycle(1'b1, 32'h48, 1'b1, 32'h400, 1'b1, 32'h48, "clr_upd");
    look(32'h48, 1'b0, 32'h4c, "clr_upd_pc");
    look(32'h44, 1'b0, 32'h48, "clr_44");
    look(32'h60, 1'b0, 32'h64, "clr_60");

    // Asynchronous reset in the middle of an update leaves nothing behind.
    cycle(1'b1, 32'h60, 1'b1, 32'h500, 1'b0, 32'h60, "pre_rst");
    update_en = 1'b1; update_pc = 32'h80; update_taken = 1'b1; update_target = 32'h600;
    #2;
    nRST = 1'b0;
    model_reset();
    pc = 32'h60;
    #1;
    cmp("mid_rst", 1'b0, 32'h64);
    update_en = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    look(32'h60, 1'b0, 32'h64, "post_rst_60");
    look(32'h80, 1'b0, 32'h84, "post_rst_80");

    // Random traffic over a small address pool so that hits and aliases are frequent.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] upc;
      logic [31:0] lpc;
      upc = {$urandom_range(0, 63)} << 2;
      upc[1:0] = 2'($urandom_range(0, 3));
      lpc = ($urandom_range(0, 3) == 0) ? $urandom : ({$urandom_range(0, 63)} << 2);
      if ($urandom_range(0, 1) == 0) lpc = upc;
      cycle(1'($urandom_range(0, 3) != 0), upc, 1'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 49) == 0), lpc, "rand");
    end
    for (int a = 0; a < 64; a++) begin
      pc = a * 4;
      #1;
      cmp_model("sweep");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
